pov_scan_ctrl: RTL and testbench



---
 rtl/pov_pkg.sv | 16 +
 rtl/period_meter.sv | 58 +++++
 rtl/pov_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pov_scan_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pov_pkg.sv
// Shared types and width helpers for the POV globe scan controller.
package pov_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } pov_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/period_meter.sv
// Measures the rotation period between index pulses and derives per-column
// tick count, the overspeed flag and the stalled (no index) flag.
module period_meter #(
    parameter int ROWS      = 6,
    parameter int COLS_LOG2 = 6,
    parameter int ROW_TICKS = 16,
    parameter int PERIOD_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                index_evt,
    output logic [PERIOD_W-1:0] col_ticks,
    output logic                overspeed,
    output logic                ovs_next,
    output logic                stalled,
    output logic                sat
);

    localparam logic [PERIOD_W-1:0] CNT_MAX    = '1;
    localparam logic [PERIOD_W-1:0] SCAN_TICKS = PERIOD_W'(ROWS * ROW_TICKS);

    function automatic logic [PERIOD_W-1:0] ticks_of(input logic [PERIOD_W-1:0] p);
        logic [PERIOD_W-1:0] s;
        s = p >> COLS_LOG2;
        return (s == '0) ? PERIOD_W'(1) : s;
    endfunction

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period;

    // ovs_next lets the scanner gate the very first strobe after an index
    // with the overspeed value that the new period is about to produce.
    always_comb begin
        col_ticks = ticks_of(period);
        ovs_next  = (ticks_of(cnt) < SCAN_TICKS);
        sat       = !clear && !index_evt && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt       <= '0;
            period    <= '0;
            overspeed <= 1'b0;
            stalled   <= 1'b0;
        end else if (index_evt) begin
            period    <= cnt;
            cnt       <= PERIOD_W'(1);
            overspeed <= ovs_next;
            stalled   <= 1'b0;
        end else if (sat) begin
            stalled   <= 1'b1;
        end else begin
            cnt       <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pov_scan_ctrl.sv
// POV globe scan controller: slices each revolution into columns and walks
// the row-select shift register through one-hot row slots per column.
module pov_scan_ctrl
    import pov_pkg::*;
#(
    parameter int ROWS      = 6,
    parameter int COLS_LOG2 = 6,
    parameter int ROW_TICKS = 16,
    parameter int PERIOD_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     index,
    output logic                     sr_d,
    output logic                     sr_shift,
    output logic                     pix_rd,
    output logic [COLS_LOG2-1:0]     col_addr,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     blank,
    output logic                     overspeed,
    output logic                     stalled,
    output pov_state_t               dbg_state
);

    localparam int ROW_W  = $clog2(ROWS);
    localparam int RCNT_W = cnt_w(ROWS + 1);
    localparam int SLOT_W = cnt_w(ROW_TICKS);
    localparam logic [RCNT_W-1:0] ROWS_C    = RCNT_W'(ROWS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(ROW_TICKS - 1);

    pov_state_t            state_q, state_d;
    logic                  armed_q, armed_d;
    logic [COLS_LOG2-1:0]  col_q, col_d;
    logic [PERIOD_W-1:0]   ct_q, ct_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [RCNT_W-1:0]     row_q, row_d;

    logic                  strobe_d, sr_d_d, blank_d;
    logic [COLS_LOG2-1:0]  col_addr_d;
    logic [ROW_W-1:0]      row_idx_d;

    logic                  index_evt, clear, go_run, ovs_eff;
    logic [PERIOD_W-1:0]   col_ticks;
    logic                  ovs_next, sat;

    assign index_evt = enable && index && (state_q != IDLE);
    assign clear     = !enable || (state_q == IDLE);
    assign dbg_state = state_q;

    period_meter #(
        .ROWS      (ROWS),
        .COLS_LOG2 (COLS_LOG2),
        .ROW_TICKS (ROW_TICKS),
        .PERIOD_W  (PERIOD_W)
    ) u_meter (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .index_evt (index_evt),
        .col_ticks (col_ticks),
        .overspeed (overspeed),
        .ovs_next  (ovs_next),
        .stalled   (stalled),
        .sat       (sat)
    );

    // Frame-memory handshake: pix_rd is a one-cycle request with no ready;
    // col_addr/row_idx are valid in that cycle and held until the next
    // strobe, and the memory must accept every request it is shown.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        col_d      = col_q;
        ct_d       = ct_q;
        slot_d     = slot_q;
        row_d      = row_q;
        strobe_d   = 1'b0;
        sr_d_d     = 1'b0;
        blank_d    = 1'b1;
        col_addr_d = col_addr;
        row_idx_d  = row_idx;
        go_run     = index_evt && ((state_q != SYNC) || armed_q);
        ovs_eff    = index_evt ? ovs_next : overspeed;

        case (state_q)
            IDLE: begin
                armed_d    = 1'b0;
                col_d      = '0;
                ct_d       = '0;
                slot_d     = '0;
                row_d      = '0;
                col_addr_d = '0;
                row_idx_d  = '0;
                if (enable) state_d = SYNC;
            end
            SYNC: begin
                if (index_evt && !armed_q) armed_d = 1'b1;
            end
            RUN: begin
                if (ct_q == col_ticks - PERIOD_W'(1)) begin
                    if (col_q == '1) begin
                        state_d = HOLD;
                    end else begin
                        col_d  = col_q + 1'b1;
                        ct_d   = '0;
                        slot_d = '0;
                        row_d  = '0;
                    end
                end else begin
                    ct_d = ct_q + 1'b1;
                    if (slot_q == LAST_SLOT) begin
                        slot_d = '0;
                        row_d  = (row_q == ROWS_C) ? row_q : row_q + 1'b1;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            HOLD: begin
            end
        endcase

        if (go_run) begin
            state_d = RUN;
            col_d   = '0;
            ct_d    = '0;
            slot_d  = '0;
            row_d   = '0;
        end

        // Saturated period counter: lost the index, re-measure from scratch.
        if (sat) begin
            state_d    = SYNC;
            armed_d    = 1'b0;
            col_d      = '0;
            ct_d       = '0;
            slot_d     = '0;
            row_d      = '0;
            col_addr_d = '0;
            row_idx_d  = '0;
        end

        if (!enable) begin
            state_d    = IDLE;
            armed_d    = 1'b0;
            col_d      = '0;
            ct_d       = '0;
            slot_d     = '0;
            row_d      = '0;
            col_addr_d = '0;
            row_idx_d  = '0;
        end

        if (state_d == RUN) begin
            col_addr_d = col_d;
            if (!ovs_eff && (row_d < ROWS_C)) begin
                blank_d = 1'b0;
                if (slot_d == '0) begin
                    strobe_d  = 1'b1;
                    sr_d_d    = (row_d == '0);
                    row_idx_d = row_d[ROW_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            armed_q  <= 1'b0;
            col_q    <= '0;
            ct_q     <= '0;
            slot_q   <= '0;
            row_q    <= '0;
            sr_d     <= 1'b0;
            sr_shift <= 1'b0;
            pix_rd   <= 1'b0;
            col_addr <= '0;
            row_idx  <= '0;
            blank    <= 1'b1;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            col_q    <= col_d;
            ct_q     <= ct_d;
            slot_q   <= slot_d;
            row_q    <= row_d;
            sr_d     <= sr_d_d;
            sr_shift <= strobe_d;
            pix_rd   <= strobe_d;
            col_addr <= col_addr_d;
            row_idx  <= row_idx_d;
            blank    <= blank_d;
        end
    end

endmodule

// File: tb/tb_pov_scan_ctrl.sv
// Bench for pov_scan_ctrl: index schedules drive a revolution-level model
// whose expected strobes are queued and matched by an independent monitor.
module tb_pov_scan_ctrl;
    import pov_pkg::*;

    localparam int ROWS      = 6;
    localparam int COLS_LOG2 = 2;
    localparam int ROW_TICKS = 4;
    localparam int PERIOD_W  = 12;
    localparam int NCOLS     = 1 << COLS_LOG2;
    localparam int SCAN      = ROWS * ROW_TICKS;
    localparam int W         = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic index = 1'b0;
    logic sr_d, sr_shift, pix_rd, blank, overspeed, stalled;
    logic [COLS_LOG2-1:0] col_addr;
    logic [2:0] row_idx;
    pov_state_t dbg_state;

    int cyc = 0;
    int t_last = 0;
    int n_checks = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;

    pov_scan_ctrl #(
        .ROWS      (ROWS),
        .COLS_LOG2 (COLS_LOG2),
        .ROW_TICKS (ROW_TICKS),
        .PERIOD_W  (PERIOD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .index     (index),
        .sr_d      (sr_d),
        .sr_shift  (sr_shift),
        .pix_rd    (pix_rd),
        .col_addr  (col_addr),
        .row_idx   (row_idx),
        .blank     (blank),
        .overspeed (overspeed),
        .stalled   (stalled),
        .dbg_state (dbg_state)
    );

    // Clock / cycle counter: cycle n is the interval after the n-th posedge.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    function automatic logic [W-1:0] pack(input int c, input int col, input int row, input bit d);
        return {c[15:0], col[1:0], row[2:0], d};
    endfunction

    // Reference model: a revolution started at index cycle t with period p
    // strobes row r of column c at t+1+c*ct+r*ROW_TICKS, cut off by the next event.
    task automatic push_rev(input int t, input int p, input int cutoff, output bit ovs);
        int ct;
        int s;
        ct = p >> COLS_LOG2;
        if (ct < 1) ct = 1;
        ovs = (ct < SCAN);
        if (!ovs) begin
            for (int c = 0; c < NCOLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    s = t + 1 + c * ct + r * ROW_TICKS;
                    if (s <= cutoff) exp_q.push_back(pack(s, c, r, (r == 0)));
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm();
        t_last = cyc;
        index = 1'b1;
        step(1);
        index = 1'b0;
    endtask

    task automatic index_rev(input int gap);
        int t;
        bit ovs;
        t = cyc;
        push_rev(t, t - t_last, t + gap, ovs);
        t_last = t;
        index = 1'b1;
        step(1);
        index = 1'b0;
        chk("overspeed", int'(overspeed), int'(ovs));
    endtask

    task automatic do_rev(input int gap);
        int t;
        t = cyc;
        index_rev(gap);
        wait_until(t + gap);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sr_d"}, int'(sr_d), 0);
        chk({tag, "_sr_shift"}, int'(sr_shift), 0);
        chk({tag, "_pix_rd"}, int'(pix_rd), 0);
        chk({tag, "_col_addr"}, int'(col_addr), 0);
        chk({tag, "_row_idx"}, int'(row_idx), 0);
        chk({tag, "_blank"}, int'(blank), 1);
        chk({tag, "_overspeed"}, int'(overspeed), 0);
        chk({tag, "_stalled"}, int'(stalled), 0);
        chk({tag, "_state"}, int'(dbg_state), int'(IDLE));
    endtask

    // Monitor: every strobe cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (pix_rd === 1'b1 || sr_shift === 1'b1) begin
            chk("strobe_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                chk("strobe_cyc_col_row_d", int'(pack(cyc, int'(col_addr), int'(row_idx), sr_d)), int'(exp_e));
                chk("strobe_pins", int'({pix_rd, sr_shift, blank}), 3'b110);
            end
        end
    end

    int nb;
    int t0;
    int fixed_gaps[7] = '{256, 100, 80, 95, 96, 256, 300};

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        step(3);
        chk_reset("reset");
        rst = 1'b0;
        step(1);
        chk("state_sync_after_reset", int'(dbg_state), int'(SYNC));
        step(20);
        arm();
        wait_until(t_last + 256);

        // 256-cycle revolution, then a late index leaves time for HOLD.
        t0 = cyc;
        index_rev(300);
        nb = 0;
        for (int i = 0; i < 64; i++) begin
            if (blank) nb++;
            step(1);
        end
        chk("blank_cycles_col0", nb, 40);
        wait_until(t0 + 270);
        chk("hold_state", int'(dbg_state), int'(HOLD));
        chk("hold_blank", int'(blank), 1);
        wait_until(t0 + 300);

        foreach (fixed_gaps[i]) do_rev(fixed_gaps[i]);
        for (int i = 0; i < 12; i++) do_rev($urandom_range(60, 450));

        // Withheld index: the period counter saturates.
        t0 = cyc;
        index_rev(5000);
        wait_until(t0 + 4094);
        chk("stalled_before_sat", int'(stalled), 0);
        wait_until(t0 + 4096);
        chk("stalled_after_sat", int'(stalled), 1);
        chk("state_after_sat", int'(dbg_state), int'(SYNC));
        chk("blank_after_sat", int'(blank), 1);
        step(50);
        arm();
        chk("stalled_cleared", int'(stalled), 0);
        wait_until(t_last + 200);
        do_rev(256);

        // Enable dropped mid-row.
        t0 = cyc;
        index_rev(10);
        wait_until(t0 + 10);
        enable = 1'b0;
        step(1);
        chk_reset("enable_drop");
        step(30);
        enable = 1'b1;
        step(5);
        arm();
        wait_until(t_last + 256);

        // Reset pulsed mid-row.
        t0 = cyc;
        index_rev(13);
        wait_until(t0 + 13);
        rst = 1'b1;
        step(1);
        chk_reset("rst_pulse");
        step(2);
        rst = 1'b0;
        step(5);
        arm();
        wait_until(t_last + 256);

        index_rev(2000);
        step(400);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
